touch_adc_scanner: RTL and testbench

Parametrised successor to the team's single-purpose touchpad controller. It scans NUM_CH channels of an SPI touch ADC (ADS7843-style, 24-clock conversions) with configurable command bytes, power-of-two averaging and pen-down gating. All logic runs in the cclk domain; touch_clk is an output generated with clock-enable strobes and is never used as a clock.

---
 rtl/touch_adc_scanner_pkg.sv | 19 +
 rtl/touch_sclk_gen.sv | 51 +++++
 rtl/touch_adc_scanner.sv | 197 +++++++++++++++++++
 tb/tb_touch_adc_scanner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_adc_scanner_pkg.sv
// Shared types and constants for the touch ADC scanner.
// Holds default ADC command bytes, FSM state encoding and SPI frame geometry.
package touch_pkg;

    localparam logic [7:0] CMD_X = 8'hD3;
    localparam logic [7:0] CMD_Y = 8'h93;
    localparam logic [7:0] CMD_Z = 8'hB3;

    localparam int SHIFT_LEN  = 24;
    localparam int DATA_FIRST = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_e;

endpackage

// File: rtl/touch_sclk_gen.sv
// Serial clock phase generator: counts cclk cycles and toggles a phase bit.
// Ports: clk_i/rstb_i clock and async reset, run_i enables counting (cleared
// when low), phase_o current phase, rise_o/fall_o one-cycle toggle strobes.
module touch_sclk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk_i,
    input  logic rstb_i,
    input  logic run_i,
    output logic phase_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          tc;

    assign tc      = run_i && (cnt_q == TC);
    assign rise_o  = tc && !phase_q;
    assign fall_o  = tc && phase_q;
    assign phase_o = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tc) begin
            cnt_d   = '0;
            phase_d = !phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/touch_adc_scanner.sv
// Multi-channel SPI touch ADC scanner with averaging and pen-down gating.
// Ports: cclk/rstb, enable, ch_cmd, gate_thresh, touch_busy, data_in in;
// touch_clk, data_out, touch_csb, sample, frame_valid/drop, pen_down,
// busy_retry, dbg_state out.
module touch_adc_scanner
    import touch_pkg::*;
#(
    parameter int CLK_DIV  = 25,
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 3,
    parameter int GATE_EN  = 1,
    parameter int GAP_SCLK = 2
) (
    input  logic                     cclk,
    input  logic                     rstb,
    input  logic                     enable,
    input  logic [8*NUM_CH-1:0]      ch_cmd,
    input  logic [DATA_W-1:0]        gate_thresh,
    input  logic                     touch_busy,
    input  logic                     data_in,
    output logic                     touch_clk,
    output logic                     data_out,
    output logic                     touch_csb,
    output logic [DATA_W*NUM_CH-1:0] sample,
    output logic                     frame_valid,
    output logic                     frame_drop,
    output logic                     pen_down,
    output logic                     busy_retry,
    output logic [1:0]               dbg_state
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAP_W = $clog2(GAP_SCLK + 1);
    localparam int SMP_W = DATA_W * NUM_CH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_SCLK - 1);
    localparam logic [4:0]       P_LAST   = 5'(SHIFT_LEN - 1);
    localparam logic [4:0]       P_BUSY   = 5'(DATA_FIRST - 1);
    localparam logic [4:0]       P_D0     = 5'(DATA_FIRST);
    localparam logic [4:0]       P_DEND   = 5'(DATA_FIRST + DATA_W);

    state_e state_q, state_d;

    logic              run, rise, fall, phase;
    logic [4:0]        p_q;
    logic [GAP_W-1:0]  gap_q;
    logic [CH_W-1:0]   ch_q;
    logic [7:0]        cmd_q;
    logic [DATA_W-1:0] thr_q, shreg_q, avg;
    logic              busy_q, dout_q, pen_q;
    logic              fv_q, fd_q, retry_q;
    logic [ACC_W-1:0]  acc_q, acc_sum;
    logic [CNT_W-1:0]  cnt_q;
    logic [SMP_W-1:0]  shadow_q, shadow_d, sample_q;
    logic              conv_done, gap_done, enter_setup;
    logic              pen_cmp, pen_now, commit_ok;

    assign run = (state_q != S_IDLE);

    touch_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk (
        .clk_i   (cclk),
        .rstb_i  (rstb),
        .run_i   (run),
        .phase_o (phase),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    assign conv_done = fall && (state_q == S_SHIFT) && (p_q == P_LAST);
    assign gap_done  = fall && (state_q == S_GAP) && (gap_q == GAP_LAST);
    assign enter_setup = enable &&
                         ((state_q == S_IDLE) || gap_done);

    assign acc_sum = acc_q + ACC_W'(shreg_q);
    assign avg     = DATA_W'(acc_sum >> AVG_LOG2);
    assign pen_cmp = (avg >= thr_q);
    // Single-channel frames gate on the comparison made this very cycle.
    assign pen_now   = (ch_q == '0) ? pen_cmp : pen_q;
    assign commit_ok = (GATE_EN == 0) || pen_now;

    always_comb begin
        shadow_d = shadow_q;
        shadow_d[DATA_W*ch_q +: DATA_W] = avg;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enable) state_d = S_SETUP;
            S_SETUP: if (rise) state_d = S_SHIFT;
            S_SHIFT: if (conv_done) state_d = S_GAP;
            S_GAP:   if (gap_done) state_d = enable ? S_SETUP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            p_q      <= '0;
            gap_q    <= '0;
            ch_q     <= '0;
            cmd_q    <= '0;
            thr_q    <= '0;
            shreg_q  <= '0;
            busy_q   <= 1'b0;
            dout_q   <= 1'b0;
            pen_q    <= 1'b0;
            fv_q     <= 1'b0;
            fd_q     <= 1'b0;
            retry_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            sample_q <= '0;
        end else begin
            fv_q    <= 1'b0;
            fd_q    <= 1'b0;
            retry_q <= 1'b0;
            if (enter_setup) begin
                cmd_q  <= ch_cmd[8*ch_q +: 8];
                dout_q <= ch_cmd[8*ch_q + 7];
                thr_q  <= gate_thresh;
            end
            if (state_q == S_SHIFT && rise) begin
                if (p_q == P_BUSY) busy_q <= touch_busy;
                if (p_q >= P_D0 && p_q < P_DEND)
                    shreg_q <= {shreg_q[DATA_W-2:0], data_in};
            end
            // cmd_q doubles as the command shifter; zero fill gives
            // data_out=0 from period 8 onwards.
            if (state_q == S_SHIFT && fall) begin
                dout_q <= cmd_q[6];
                cmd_q  <= {cmd_q[6:0], 1'b0};
                p_q    <= conv_done ? '0 : p_q + 1'b1;
            end
            if (conv_done) begin
                if (busy_q) begin
                    retry_q <= 1'b1;
                end else if (cnt_q != CNT_LAST) begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    ch_q  <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                    if (ch_q == '0) begin
                        sample_q[DATA_W-1:0] <= avg;
                        if (GATE_EN != 0) pen_q <= pen_cmp;
                    end else begin
                        shadow_q <= shadow_d;
                    end
                    if (ch_q == CH_LAST) begin
                        if (commit_ok) begin
                            for (int i = 1; i < NUM_CH; i++)
                                sample_q[DATA_W*i +: DATA_W] <=
                                    shadow_d[DATA_W*i +: DATA_W];
                            fv_q <= 1'b1;
                        end else begin
                            fd_q <= 1'b1;
                        end
                    end
                end
            end
            if (state_q == S_GAP && fall)
                gap_q <= gap_done ? '0 : gap_q + 1'b1;
            // Stopping discards any partially built frame.
            if (gap_done && !enable) begin
                acc_q    <= '0;
                cnt_q    <= '0;
                ch_q     <= '0;
                shadow_q <= '0;
            end
        end
    end

    assign touch_clk   = phase && (state_q == S_SHIFT);
    assign touch_csb   = !((state_q == S_SETUP) || (state_q == S_SHIFT));
    assign data_out    = dout_q;
    assign sample      = sample_q;
    assign frame_valid = fv_q;
    assign frame_drop  = fd_q;
    assign pen_down    = pen_q;
    assign busy_retry  = retry_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_touch_adc_scanner.sv
// Scoreboard bench for touch_adc_scanner with a behavioural SPI ADC model.
// Three channels (z, x, y), 8-way averaging, pen-down gating enabled.
module tb_touch_adc_scanner;
    import touch_pkg::*;

    logic        cclk = 1'b0;
    logic        rstb = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] ch_cmd;
    logic [11:0] gate_thresh = 12'h040;
    logic        touch_busy = 1'b0;
    logic        data_in = 1'b0;
    logic        touch_clk, data_out, touch_csb;
    logic [35:0] sample;
    logic        frame_valid, frame_drop, pen_down, busy_retry;
    logic [1:0]  dbg_state;

    touch_adc_scanner #(
        .CLK_DIV(2), .NUM_CH(3), .DATA_W(12),
        .AVG_LOG2(3), .GATE_EN(1), .GAP_SCLK(2)
    ) dut (
        .cclk(cclk), .rstb(rstb), .enable(enable),
        .ch_cmd(ch_cmd), .gate_thresh(gate_thresh),
        .touch_busy(touch_busy), .data_in(data_in),
        .touch_clk(touch_clk), .data_out(data_out),
        .touch_csb(touch_csb), .sample(sample),
        .frame_valid(frame_valid), .frame_drop(frame_drop),
        .pen_down(pen_down), .busy_retry(busy_retry),
        .dbg_state(dbg_state)
    );

    always #5 cclk = ~cclk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic        drop;
        logic        pen;
        logic [35:0] smp;
    } exp_t;

    exp_t sb[$];

    logic [7:0] cmds [3];

    function automatic logic [11:0] valf(input int fr, input int ch,
                                         input int k);
        case (fr)
            0: return (ch == 0) ? 12'(12'h100 + k) :
                      (ch == 1) ? 12'(12'h120 + k) : 12'h456;
            1: return (ch == 0) ? 12'h010 :
                      (ch == 1) ? 12'h111 : 12'h222;
            2: return (ch == 0) ? 12'h200 :
                      (ch == 1) ? 12'h345 : 12'h678;
            default: return 12'h0AA;
        endcase
    endfunction

    // ADC model, polled away from the active cclk edge.
    int         cnt_m = 0;
    int         exp_ch = 0;
    int         k_m = 0;
    int         frame_m = 0;
    int         conv_ends = 0;
    logic [7:0] cmd_m = '0;
    logic [11:0] val_m = '0;
    logic       busy_cur = 0;
    logic       inj_done = 0;
    logic       dout_bad = 0;
    logic       pclk = 0;
    logic       pcsb = 1;

    always @(negedge cclk) begin
        if (!rstb) begin
            cnt_m = 0; exp_ch = 0; k_m = 0; busy_cur = 0;
            touch_busy = 0; data_in = 0; pclk = 0; pcsb = 1;
        end else begin
            if (pcsb && !touch_csb) begin
                cnt_m = 0;
                dout_bad = 0;
            end
            if (!pclk && touch_clk) begin
                if (cnt_m < 8) cmd_m = {cmd_m[6:0], data_out};
                else if (data_out !== 1'b0) dout_bad = 1;
                cnt_m++;
            end
            if (pclk && !touch_clk) begin
                if (cnt_m == 8) begin
                    chk("cmd_bits", 64'(cmd_m), 64'(cmds[exp_ch]));
                    val_m = valf(frame_m, exp_ch, k_m);
                    busy_cur = (frame_m == 0) && (exp_ch == 0) &&
                               (k_m == 3) && !inj_done;
                    if (busy_cur) inj_done = 1;
                end
                touch_busy = (cnt_m == 8) && busy_cur;
                data_in = (cnt_m >= 9 && cnt_m <= 20) ?
                          val_m[20-cnt_m] : 1'b0;
            end
            if (!pcsb && touch_csb) begin
                chk("dout_tail_zero", 64'(dout_bad), 64'(0));
                conv_ends++;
                if (!busy_cur) begin
                    k_m++;
                    if (k_m == 8) begin
                        k_m = 0;
                        if (exp_ch == 2) begin
                            exp_ch = 0;
                            frame_m++;
                        end else begin
                            exp_ch++;
                        end
                    end
                end
                busy_cur = 0;
            end
            pclk = touch_clk;
            pcsb = touch_csb;
        end
    end

    // Scoreboard monitor.
    int         ev_cnt = 0;
    int         retry_cnt = 0;
    logic [1:0] prev_st = 2'd0;
    logic       prev_fv = 0;

    always @(negedge cclk) begin
        exp_t e;
        if (rstb) begin
            if (frame_valid || frame_drop) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame: valid=%0b drop=%0b",
                             frame_valid, frame_drop);
                end else begin
                    e = sb.pop_front();
                    chk("frame_kind", 64'({frame_valid, frame_drop}),
                        64'({!e.drop, e.drop}));
                    chk("frame_sample", 64'(sample), 64'(e.smp));
                    chk("frame_pen", 64'(pen_down), 64'(e.pen));
                    chk("frame_latency", 64'({prev_st, dbg_state}),
                        64'({S_SHIFT, S_GAP}));
                end
                ev_cnt++;
            end
            if (prev_fv) chk("fv_width", 64'(frame_valid), 64'(0));
            if (busy_retry) retry_cnt++;
        end
        prev_st = dbg_state;
        prev_fv = frame_valid;
    end

    initial begin
        int base;
        cmds[0] = CMD_Z;
        cmds[1] = CMD_X;
        cmds[2] = CMD_Y;
        ch_cmd  = {CMD_Y, CMD_X, CMD_Z};

        repeat (3) @(negedge cclk);
        chk("rst_csb", 64'(touch_csb), 64'(1));
        chk("rst_clk", 64'(touch_clk), 64'(0));
        chk("rst_dout", 64'(data_out), 64'(0));
        chk("rst_sample", 64'(sample), 64'(0));
        chk("rst_pen", 64'(pen_down), 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
        rstb = 1'b1;
        @(negedge cclk);

        sb.push_back('{drop: 1'b0, pen: 1'b1,
                       smp: {12'h456, 12'h123, 12'h103}});
        sb.push_back('{drop: 1'b1, pen: 1'b0,
                       smp: {12'h456, 12'h123, 12'h010}});
        sb.push_back('{drop: 1'b0, pen: 1'b1,
                       smp: {12'h678, 12'h345, 12'h200}});
        enable = 1'b1;
        for (int i = 0; i < 20000 && ev_cnt < 3; i++) @(negedge cclk);
        chk("frames_seen", 64'(ev_cnt), 64'(3));

        // Stop part-way through a conversion.
        for (int i = 0; i < 500 && cnt_m != 13; i++) @(negedge cclk);
        chk("reach_p12", 64'(cnt_m), 64'(13));
        base = conv_ends;
        enable = 1'b0;
        for (int i = 0; i < 500 && dbg_state != S_IDLE; i++)
            @(negedge cclk);
        chk("stop_state", 64'(dbg_state), 64'(S_IDLE));
        chk("stop_conv_done", 64'(conv_ends - base), 64'(1));
        chk("stop_csb", 64'(touch_csb), 64'(1));
        chk("stop_clk", 64'(touch_clk), 64'(0));
        repeat (50) @(negedge cclk);
        chk("stay_idle", 64'(dbg_state), 64'(S_IDLE));

        // Asynchronous reset in the middle of a shift.
        enable = 1'b1;
        for (int i = 0; i < 500 &&
             !(dbg_state == S_SHIFT && touch_clk); i++)
            @(negedge cclk);
        chk("in_shift", 64'(dbg_state), 64'(S_SHIFT));
        #2 rstb = 1'b0;
        #1;
        chk("arst_csb", 64'(touch_csb), 64'(1));
        chk("arst_clk", 64'(touch_clk), 64'(0));
        chk("arst_sample", 64'(sample), 64'(0));
        chk("arst_state", 64'(dbg_state), 64'(S_IDLE));
        @(negedge cclk);
        @(negedge cclk);
        rstb = 1'b1;
        for (int i = 0; i < 50 && dbg_state != S_SETUP; i++)
            @(negedge cclk);
        chk("restart_setup", 64'(dbg_state), 64'(S_SETUP));
        chk("restart_ch0", 64'(exp_ch), 64'(0));
        base = conv_ends;
        for (int i = 0; i < 500 && conv_ends == base; i++)
            @(negedge cclk);
        chk("restart_conv", 64'(conv_ends - base), 64'(1));
        enable = 1'b0;
        for (int i = 0; i < 500 && dbg_state != S_IDLE; i++)
            @(negedge cclk);
        chk("final_idle", 64'(dbg_state), 64'(S_IDLE));

        chk("sb_left", 64'(sb.size()), 64'(0));
        chk("busy_retry_cnt", 64'(retry_cnt), 64'(1));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
